// File: rtl/sdrc_wbm_pkg.sv
// sdrc_wbm_pkg: shared types, constants and pattern helpers for the Wishbone burst master
// Contents: state_e FSM encoding, CTI codes, pattern key, LFSR polynomial,
//           pattern_f (address-XOR data) and lfsr_next_f (Galois LFSR step).
package sdrc_wbm_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [31:0] PATTERN_KEY = 32'hA5A5_0000;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [31:0] pattern_f(input logic [31:0] addr);
    return addr ^ PATTERN_KEY;
  endfunction
  function automatic logic [31:0] lfsr_next_f(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/sdrc_wbm_pattern_gen.sv
// sdrc_wbm_pattern_gen: deterministic per-beat data generator (address-XOR or Galois LFSR)
// Ports: clk, rst_n (async active-low), load_i (restart from start_i),
//        adv_i (step to next beat), start_i (burst start byte address), data_o (current beat data).
// Build option: SDRC_WBM_LFSR_PATTERN_EN selects the LFSR sequence instead of address-XOR.
module sdrc_wbm_pattern_gen
  import sdrc_wbm_pkg::*;
#(
  parameter int AW   = 26,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] start_i,
  output logic [31:0]   data_o
);
`ifdef SDRC_WBM_LFSR_PATTERN_EN
  logic [31:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? (32'(start_i) ^ PATTERN_KEY) : adv_i ? lfsr_next_f(lfsr_q) : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= '0;
    else lfsr_q <= lfsr_d;
  assign data_o = lfsr_q;
`else
  // Tracks the beat address on its own so data is a pure function of the beat position.
  logic [AW-1:0] addr_q, addr_d;
  always_comb addr_d = load_i ? start_i : adv_i ? addr_q + AW'(STEP) : addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_q <= '0;
    else addr_q <= addr_d;
  assign data_o = pattern_f(32'(addr_q));
`endif
endmodule

// File: rtl/sdrc_wb_burst_master.sv
// sdrc_wb_burst_master: Wishbone burst master generating pattern writes and checked reads
// Ports:
//   sys_clk, resetn (async active-low)
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len : one-at-a-time command (len 0 => 1 beat)
//   err_clr                                     : clears err_cnt, first_err_addr, timeout
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_addr_o/wb_dat_o/wb_sel_o/wb_cti_o, wb_ack_i/wb_dat_i : Wishbone master
//   busy, done (1-cycle pulse), err_cnt (saturating), first_err_addr, timeout (sticky)
// Build option: SDRC_WBM_LFSR_PATTERN_EN switches the data pattern to a Galois LFSR.
module sdrc_wb_burst_master
  import sdrc_wbm_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int SDR_DW = 32,
  parameter int SDR_BW = 4,
  parameter int BL_W   = 8,
  parameter int TO_CYC = 1023
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [BL_W-1:0]   cmd_len,
  input  logic              err_clr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [SDR_DW-1:0] wb_dat_o,
  output logic [SDR_BW-1:0] wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [SDR_DW-1:0] wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              timeout
);
  localparam int SW = $clog2(TO_CYC + 1);
  state_e state_q, state_d;
  logic we_q, we_d;
  logic [APP_AW-1:0] addr_q, addr_d, first_q, first_d;
  logic [BL_W-1:0] rem_q, rem_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0] err_q, err_d, err_base;
  logic to_q, to_d;
  logic in_burst, load, ack, last, stall_hit, mismatch;
  logic [31:0] wr_data, exp_data;
  assign in_burst = state_q == BURST;
  assign load = state_q == IDLE && cmd_valid;
  assign ack = in_burst && wb_ack_i;
  assign last = rem_q == BL_W'(1);
  assign stall_hit = in_burst && !wb_ack_i && stall_q == SW'(TO_CYC - 1);
  assign mismatch = ack && !we_q && wb_dat_i != exp_data;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = BURST;
      BURST:   if ((ack && last) || stall_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    we_d = load ? cmd_wr : we_q;
    addr_d = load ? cmd_addr : ack ? addr_q + APP_AW'(SDR_BW) : addr_q;
    rem_d = load ? (cmd_len == '0 ? BL_W'(1) : cmd_len) : ack ? rem_q - BL_W'(1) : rem_q;
    stall_d = (!in_burst || ack) ? '0 : stall_q + SW'(1);
    // Clear is applied first so a same-cycle mismatch still registers as the first error.
    err_base = err_clr ? '0 : err_q;
    err_d = (mismatch && err_base != 16'hFFFF) ? err_base + 16'd1 : err_base;
    first_d = (mismatch && err_base == '0) ? addr_q : err_clr ? '0 : first_q;
    to_d = stall_hit || (!err_clr && to_q);
  end
  always_ff @(posedge sys_clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      rem_q <= '0;
      stall_q <= '0;
      err_q <= '0;
      first_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      stall_q <= stall_d;
      err_q <= err_d;
      first_q <= first_d;
      to_q <= to_d;
    end
`ifdef SDRC_WBM_LFSR_PATTERN_EN
  sdrc_wbm_pattern_gen #(.AW(APP_AW), .STEP(SDR_BW)) u_wr_gen (
    .clk(sys_clk), .rst_n(resetn), .load_i(load), .adv_i(ack && we_q),
    .start_i(cmd_addr), .data_o(wr_data)
  );
  sdrc_wbm_pattern_gen #(.AW(APP_AW), .STEP(SDR_BW)) u_exp_gen (
    .clk(sys_clk), .rst_n(resetn), .load_i(load), .adv_i(ack && !we_q),
    .start_i(cmd_addr), .data_o(exp_data)
  );
`else
  sdrc_wbm_pattern_gen #(.AW(APP_AW), .STEP(SDR_BW)) u_gen (
    .clk(sys_clk), .rst_n(resetn), .load_i(load), .adv_i(ack),
    .start_i(cmd_addr), .data_o(wr_data)
  );
  assign exp_data = wr_data;
`endif
  // Bus outputs derive from registered state so an async reset drops cyc/stb immediately.
  assign cmd_ready = state_q == IDLE;
  assign wb_cyc_o = in_burst;
  assign wb_stb_o = in_burst;
  assign wb_we_o = in_burst && we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o = (in_burst && we_q) ? wr_data : '0;
  assign wb_sel_o = in_burst ? '1 : '0;
  assign wb_cti_o = in_burst ? (last ? CTI_EOB : CTI_INCR) : 3'b000;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err_cnt = err_q;
  assign first_err_addr = first_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_sdrc_wb_burst_master.sv
// tb_sdrc_wb_burst_master: directed self-checking bench for the Wishbone burst master
module tb_sdrc_wb_burst_master;
  logic sys_clk = 1'b0, resetn = 1'b1, cmd_valid = 1'b0, cmd_wr = 1'b0, err_clr = 1'b0, wb_ack_i = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [31:0] wb_dat_i = '0;
  logic cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, busy, done, timeout;
  logic [25:0] wb_addr_o, first_err_addr;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_cti_o;
  logic [15:0] err_cnt;
  int n_assert = 0, n_fail = 0, n = 0;
  always #5 sys_clk = ~sys_clk;
  sdrc_wb_burst_master dut (
    .sys_clk(sys_clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .err_clr(err_clr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge sys_clk);
  endtask
  task automatic start(input logic wr, input logic [25:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_addr = a;
    cmd_len = l;
    tick;
    cmd_valid = 1'b0;
  endtask
  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_cti", wb_cti_o, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_to", timeout, 0);
    tick;
    resetn = 1'b1;
    tick;
    // 4-beat write at 0x40, ack every cycle
    wb_ack_i = 1'b1;
    start(1'b1, 26'h40, 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk("w1_cyc", wb_cyc_o, 1);
      chk("w1_we", wb_we_o, 1);
      chk("w1_sel", wb_sel_o, 4'hF);
      chk("w1_addr", wb_addr_o, 64'h40 + 4 * i);
      chk("w1_cti", wb_cti_o, i == 3 ? 3'b111 : 3'b010);
      chk("w1_dat", wb_dat_o, 64'hA5A5_0040 + 4 * i);
      tick;
    end
    chk("w1_done", done, 1);
    chk("w1_cyc_off", wb_cyc_o, 0);
    chk("w1_busy", busy, 1);
    tick;
    chk("w1_done_off", done, 0);
    chk("w1_ready", cmd_ready, 1);
    // read-back with correct data
    start(1'b0, 26'h40, 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk("r1_we", wb_we_o, 0);
      chk("r1_addr", wb_addr_o, 64'h40 + 4 * i);
      wb_dat_i = 32'hA5A5_0040 + 32'(4 * i);
      tick;
    end
    chk("r1_done", done, 1);
    chk("r1_err", err_cnt, 0);
    chk("r1_to", timeout, 0);
    tick;
    // 2-beat read at 0x100, second beat corrupted
    start(1'b0, 26'h100, 8'd2);
    chk("r2_cti0", wb_cti_o, 3'b010);
    wb_dat_i = 32'hA5A5_0100;
    tick;
    chk("r2_cti1", wb_cti_o, 3'b111);
    wb_dat_i = 32'h0;
    tick;
    chk("r2_err", err_cnt, 1);
    chk("r2_first", first_err_addr, 26'h104);
    tick;
    // second bad read keeps the first error address
    start(1'b0, 26'h200, 8'd1);
    wb_dat_i = 32'h0;
    tick;
    chk("r3_err", err_cnt, 2);
    chk("r3_first", first_err_addr, 26'h104);
    tick;
    // err_clr coinciding with a mismatch
    start(1'b0, 26'h300, 8'd1);
    wb_dat_i = 32'h0;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr_err", err_cnt, 1);
    chk("clr_first", first_err_addr, 26'h300);
    tick;
    // single beat (len 0) write with ack delayed 5 cycles
    wb_ack_i = 1'b0;
    start(1'b1, 26'h8, 8'd0);
    for (int i = 0; i < 6; i++) begin
      chk("sb_stb", wb_stb_o, 1);
      chk("sb_addr", wb_addr_o, 26'h8);
      chk("sb_dat", wb_dat_o, 32'hA5A5_0008);
      chk("sb_cti", wb_cti_o, 3'b111);
      if (i == 5) wb_ack_i = 1'b1;
      tick;
    end
    chk("sb_done", done, 1);
    chk("sb_cyc_off", wb_cyc_o, 0);
    tick;
    // ack never arrives: timeout abort
    wb_ack_i = 1'b0;
    start(1'b0, 26'h0, 8'd1);
    n = 0;
    while (wb_cyc_o && n < 2000) begin
      n++;
      tick;
    end
    chk("to_stall_cycles", n, 1023);
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_err_kept", err_cnt, 1);
    tick;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("to_clr", timeout, 0);
    chk("to_clr_err", err_cnt, 0);
    chk("to_clr_first", first_err_addr, 0);
    // async reset in the middle of an 8-beat write
    wb_ack_i = 1'b1;
    start(1'b1, 26'h500, 8'd8);
    tick;
    tick;
    tick;
    chk("ar_addr", wb_addr_o, 26'h50C);
    #2 resetn = 1'b0;
    #1;
    chk("ar_cyc", wb_cyc_o, 0);
    chk("ar_stb", wb_stb_o, 0);
    chk("ar_busy", busy, 0);
    tick;
    resetn = 1'b1;
    tick;
    chk("ar_ready", cmd_ready, 1);
    start(1'b1, 26'h600, 8'd2);
    chk("ar_new_cyc", wb_cyc_o, 1);
    chk("ar_new_addr", wb_addr_o, 26'h600);
    chk("ar_new_dat", wb_dat_o, 32'hA5A5_0600);
    chk("ar_new_cti", wb_cti_o, 3'b010);
    tick;
    chk("ar_new_addr1", wb_addr_o, 26'h604);
    chk("ar_new_cti1", wb_cti_o, 3'b111);
    tick;
    chk("ar_new_done", done, 1);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
